hilo_div_ctrl: RTL
==================

# hilo_div_ctrl

Multi-cycle divide sequencer for the execute stage. It accepts a DIV/DIVU request and runs a 32-iteration restoring division. While the division is in progress it holds the pipeline with a stall. When the division completes, it presents the {remainder, quotient} pair as a 64-bit HI/LO write for the existing HILO forwarding and write path. It owns the only divide datapath and arbitrates its use between the issuing instruction and pipeline flushes.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, execute-stage DIV/DIVU valid; sampled only in IDLE.
- signed_div, input, 1, 1 = DIV (signed), 0 = DIVU; captured with start.
- a, input, WIDTH, dividend (rs); captured with start.
- b, input, WIDTH, divisor (rt); captured with start.
- annul, input, 1, flush of the owning instruction; aborts the operation.
- stall_o, output, 1, pipeline hold request.
- ready_o, output, 1, result valid strobe (one cycle).
- hilo_write_o, output, 1, HI/LO write enable; equals ready_o.
- result_o, output, 2*WIDTH, {HI = remainder, LO = quotient}.

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state IDLE, count 0, result_o 0, ready_o 0, hilo_write_o 0, stall_o 0.
- IDLE:
  - start & ~annul: capture operands.
  - If b == 0, go to DONE with the divide-by-zero result.
  - Otherwise go to BUSY with count 0.
  - start & annul: stay in IDLE and capture nothing.
- Signed mode:
  - Operands are converted to magnitudes at capture.
  - The quotient is negated if a[31] != b[31].
  - The remainder takes the sign of a.
  - Negation is two's complement, truncated to WIDTH.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - divisor.
  - If the trial is non-negative, rem = trial and quo[0] = 1.
  - count increments each step; after step WIDTH-1, go to DONE with sign-corrected values loaded into result_o.
  - annul in BUSY: go to IDLE next edge; result_o unchanged; no ready_o.
- DONE: ready_o = hilo_write_o = 1 for exactly one cycle, then IDLE.
  - annul in DONE has no effect; the pipeline discards the write.
- Divide by zero: quotient = all ones, remainder = a (raw, unsigned view). No exception is raised.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0, no exception.
- result_o holds its value until the next completed operation.
- stall_o is combinational:
  - (state==IDLE & start & ~annul) | state==BUSY.
  - stall_o is 0 in DONE, so the owning instruction advances in the same cycle the write is presented.

## Timing
- Normal division: start accepted at edge 0.
  - BUSY covers cycles 1..WIDTH.
  - DONE in cycle WIDTH+1 (33 for WIDTH=32), with ready_o high there.
  - Total stall is WIDTH+1 cycles, counting the accept cycle.
- Divide by zero: DONE in cycle 1; stall lasts 1 cycle.
- start is ignored in BUSY and DONE. A start held high in the DONE cycle is not re-accepted.
  - The earliest new accept is the first IDLE cycle after DONE.
- Back-to-back divides: the second start is accepted in cycle WIDTH+2.
- rst asserted mid-operation: immediately IDLE; outputs are at reset values in the same cycle. No write is issued.
- annul and the final BUSY step in the same cycle: annul wins; go to IDLE and issue no ready_o.

## Test plan
- DIVU a=100, b=7: stall_o high for 33 cycles, then ready_o in cycle 33 with result_o = {32'd2, 32'd14}, then IDLE.
- DIV a=-7 (0xFFFFFFF9), b=2: result_o = {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3). Also DIV a=7, b=-2 gives {0x00000001, 0xFFFFFFFD}.
- b=0, a=0x12345678 (either mode): ready_o in cycle 1, result_o = {0x12345678, 0xFFFFFFFF}, stall one cycle.
- DIV a=0x80000000, b=0xFFFFFFFF: result_o = {0x00000000, 0x80000000}. DIVU with the same operands gives {0x80000000, 0x00000000}.
- Start a divide, assert annul at BUSY cycle 10: IDLE next cycle, stall_o drops, no ready_o, result_o keeps its prior value. A new start in the following cycle is accepted.
- Assert rst asynchronously at BUSY cycle 5: stall_o, ready_o and result_o go to 0 without a clock edge. After release, DIVU 0xFFFFFFFF / 0x10 gives {0x0000000F, 0x0FFFFFFF}.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// Multi-cycle restoring divider for the execute stage. Accepts DIV/DIVU,
// holds the pipeline with stall_o while iterating one quotient bit per cycle,
// then presents {remainder, quotient} as a one-cycle HI/LO write.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; divide-by-zero resolves straight to DONE
// BUSY   | one restoring step per cycle, WIDTH steps in total
// DONE   | result_o valid, ready_o/hilo_write_o high for this one cycle

module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic                 hilo_write_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [CW-1:0]          count_q,   count_d;
    logic [WIDTH-1:0]       rem_q,     rem_d;
    logic [WIDTH-1:0]       quo_q,     quo_d;
    logic [WIDTH-1:0]       div_q,     div_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]     result_q,  result_d;

    // Operand conditioning and the single restoring step
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         rem_sh;
    logic [WIDTH:0]         trial;
    logic                   take;
    logic [WIDTH-1:0]       rem_step, quo_step;
    logic [WIDTH-1:0]       rem_fix,  quo_fix;

    // Magnitudes at capture time, one restoring iteration, and final sign fix-up
    always_comb begin
        a_neg    = signed_div & a[WIDTH-1];
        b_neg    = signed_div & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;

        // The shifted partial remainder needs one extra bit: it can reach
        // 2*divisor-1, and the subtraction result then always fits WIDTH bits.
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        take     = (rem_sh >= {1'b0, div_q});
        trial    = rem_sh - {1'b0, div_q};
        rem_step = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], take};

        // Quotient sign is the XOR of operand signs; remainder follows the
        // dividend. The most-negative / -1 case wraps back to itself, which
        // is the required result.
        quo_fix  = neg_quo_q ? -quo_step : quo_step;
        rem_fix  = neg_rem_q ? -rem_step : rem_step;
    end

    // Next-state, datapath loads and the stall/ready strobes
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        stall_o   = 1'b0;
        ready_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    stall_o = 1'b1;
                    if (b == '0) begin
                        // Divide by zero: raw dividend as remainder, all-ones
                        // quotient, no iteration needed.
                        result_d = {a, {WIDTH{1'b1}}};
                        state_d  = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_mag;
                        div_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        count_d   = '0;
                        state_d   = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                stall_o = 1'b1;
                if (annul) begin
                    // Flush beats the last step too; result_o is left alone.
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_step;
                    quo_d   = quo_step;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_STEP) begin
                        result_d = {rem_fix, quo_fix};
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Write goes out regardless of annul; the pipeline drops it.
                ready_o = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign hilo_write_o = ready_o;
    assign result_o     = result_q;

endmodule
